// File: rtl/write_arb_pkg.sv
// Shared sizes and FSM state type for the register-file write-port arbiter.
package write_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 3;
    localparam int PTR_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set req bit searching from ptr upward, wrapping.
module rr_priority_picker
    import write_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   idx
);

    logic [PTR_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr is assigned last.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + PTR_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/write_port_arbiter.sv
// Round-robin arbiter feeding one register-file write port; one write per two cycles.
// Optional WRITE_ARB_R0_PROTECT_EN: writes to address 0 are acked but never enabled.
module write_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ*write_arb_pkg::ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]             req_data,
    output logic [NUM_REQ-1:0]                    ack,
    output logic                                  we,
    output logic [write_arb_pkg::ADDR_W-1:0]      Addr,
    output logic [DATA_W-1:0]                     wData,
    output logic                                  busy
);

    localparam int AW = write_arb_pkg::ADDR_W;
    localparam int PW = write_arb_pkg::PTR_W;

    write_arb_pkg::arb_state_e state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     grantee_q, grantee_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              pick_valid;
    logic [PW-1:0]     pick_idx;

    rr_priority_picker u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grantee_d = grantee_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ack       = '0;
        we        = 1'b0;
        busy      = 1'b0;
        case (state_q)
            write_arb_pkg::IDLE: begin
                if (pick_valid) begin
                    state_d   = write_arb_pkg::WRITE;
                    grantee_d = pick_idx;
                    addr_d    = req_addr[pick_idx*AW +: AW];
                    data_d    = req_data[pick_idx*DATA_W +: DATA_W];
                end
            end
            write_arb_pkg::WRITE: begin
                busy    = 1'b1;
                state_d = write_arb_pkg::IDLE;
                ptr_d   = grantee_q + PW'(1);
                // A reset landing in this cycle aborts the write without acking it.
                if (!reset) begin
                    ack[grantee_q] = 1'b1;
`ifdef WRITE_ARB_R0_PROTECT_EN
                    we = (addr_q != '0);
`else
                    we = 1'b1;
`endif
                end
            end
            default: state_d = write_arb_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= write_arb_pkg::IDLE;
            ptr_q     <= '0;
            grantee_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grantee_q <= grantee_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign Addr  = addr_q;
    assign wData = data_q;

endmodule

// File: tb/tb_write_port_arbiter.sv
// Directed and random checks of write_port_arbiter against a cycle-level reference model.
module tb_write_port_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req;
    logic [11:0]   req_addr;
    logic [127:0]  req_data;
    logic [3:0]    ack;
    logic          we;
    logic [2:0]    Addr;
    logic [DW-1:0] wData;
    logic          busy;

    write_port_arbiter #(.DATA_W(DW), .NUM_REQ(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .we       (we),
        .Addr     (Addr),
        .wData    (wData),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [2:0]    a_tab [4];
    logic [DW-1:0] d_tab [4];

    // reference model: a pending write slot plus the rotating search start
    bit            m_write;
    int            m_grant, m_ptr;
    logic [2:0]    m_addr;
    logic [DW-1:0] m_data;

    logic [3:0] last_ack;
    bit         auto_drop;
    int         g_q[$];
    int         c_q[$];
    int         exp31[5] = '{0, 1, 2, 3, 0};

    task automatic apply();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*3 +: 3]   = a_tab[i];
            req_data[i*DW +: DW] = d_tab[i];
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_write = 0; m_grant = 0; m_ptr = 0; m_addr = '0; m_data = '0;
        end else if (m_write) begin
            m_write = 0;
            m_ptr   = (m_grant + 1) % 4;
        end else if (req != 4'b0) begin
            for (int k = 0; k < 4; k++) begin
                if (req[(m_ptr + k) % 4]) begin
                    m_grant = (m_ptr + k) % 4;
                    m_addr  = a_tab[m_grant];
                    m_data  = d_tab[m_grant];
                    m_write = 1;
                    break;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_ack();
        logic [3:0] e = 4'b0;
        if (m_write && !reset) e[m_grant] = 1'b1;
        return e;
    endfunction

    function automatic logic exp_we();
`ifdef WRITE_ARB_R0_PROTECT_EN
        return m_write && !reset && (m_addr != 3'd0);
`else
        return m_write && !reset;
`endif
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        #1;
        chk("ack",   ack,   exp_ack());
        chk("we",    we,    exp_we());
        chk("busy",  busy,  m_write);
        chk("Addr",  Addr,  m_addr);
        chk("wData", wData, m_data);
        last_ack = exp_ack();
        for (int i = 0; i < 4; i++) begin
            if (ack[i] === 1'b1) begin
                g_q.push_back(i);
                c_q.push_back(cyc);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic cycle_n(int n);
        repeat (n) begin
            check_all();
            tick();
            if (auto_drop) req = req & ~last_ack;
            apply();
        end
    endtask

    int wait_cnt [4];
    int max_wait;

    initial begin
        reset = 1'b1; req = 4'b0; auto_drop = 1; last_ack = 4'b0;
        for (int i = 0; i < 4; i++) begin a_tab[i] = 3'(i + 1); d_tab[i] = 32'h100 + i; end
        apply();
        tick(); tick();
        check_all();

        // single request: one-cycle latency, then we drops
        reset = 1'b0; a_tab[0] = 3'd5; d_tab[0] = 32'hA5; req = 4'b0001; apply();
        check_all();
        tick();
        check_all();
        chk("r030_we", we, 1'b1);
        chk("r030_addr", Addr, 3'd5);
        chk("r030_data", wData, 32'hA5);
        chk("r030_ack", ack, 4'b0001);
        req = req & ~last_ack;
        tick();
        check_all();
        chk("r030_we_off", we, 1'b0);
        tick();

        // all requesting constantly: 0,1,2,3,0 two cycles apart
        reset = 1'b1; tick(); reset = 1'b0;
        g_q.delete(); c_q.delete();
        auto_drop = 0; req = 4'b1111; apply();
        cycle_n(10);
        chk("r031_count", g_q.size(), 5);
        if (g_q.size() == 5) begin
            for (int k = 0; k < 5; k++) chk("r031_order", g_q[k], exp31[k]);
            for (int k = 1; k < 5; k++) chk("r031_gap", c_q[k] - c_q[k-1], 2);
        end

        // move ptr to 2, then 0011 must grant 0 then 1
        auto_drop = 1; req = 4'b0010;
        cycle_n(3);
        g_q.delete(); c_q.delete();
        req = 4'b0011;
        cycle_n(6);
        chk("r032_count", g_q.size(), 2);
        if (g_q.size() == 2) begin
            chk("r032_first", g_q[0], 0);
            chk("r032_second", g_q[1], 1);
        end

        // reset during the write of requester 3 aborts it; held req wins again
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b1000; apply();
        check_all();
        tick();
        reset = 1'b1;
        check_all();
        chk("r033_ack3", ack[3], 1'b0);
        chk("r033_we", we, 1'b0);
        tick();
        reset = 1'b0;
        check_all();
        tick();
        check_all();
        chk("r033_regrant", ack, 4'b1000);
        req = req & ~last_ack;
        tick();

        // write to register 0
        a_tab[2] = 3'd0; d_tab[2] = 32'hDEAD_BEEF; req = 4'b0100; apply();
        check_all();
        tick();
        check_all();
        chk("r034_ack", ack, 4'b0100);
        chk("r034_addr", Addr, 3'd0);
`ifdef WRITE_ARB_R0_PROTECT_EN
        chk("r034_we", we, 1'b0);
`else
        chk("r034_we", we, 1'b1);
`endif
        req = req & ~last_ack;
        tick();

        // random traffic with occasional resets
        max_wait = 0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            check_all();
            for (int i = 0; i < 4; i++) begin
                if (reset || !req[i] || last_ack[i]) wait_cnt[i] = 0;
                else wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
            tick();
            reset = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 4; i++) begin
                if (req[i] && last_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else begin a_tab[i] = 3'($urandom_range(0, 7)); d_tab[i] = $urandom; end
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    a_tab[i] = 3'($urandom_range(0, 7));
                    d_tab[i] = $urandom;
                end
            end
            apply();
        end
        chk("rand_max_wait_ok", (max_wait <= 8), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/write_port_arbiter.md
WRITE_PORT_ARBITER -- requirements
Module: write_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the write-data width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, fixed at 4, meaning the number of requesters.
REQ-003 Port clk  input  1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port req  input  4: per-requester write request; held high until the matching ack.
REQ-006 Port req_addr  input  4x3 (12, requester i at [3i+2:3i]): target register, stable while req[i]=1.
REQ-007 Port req_data  input  4xDATA_W: write data, stable while req[i]=1.
REQ-008 Port ack  output  4: one-cycle pulse to the requester whose write is being committed.
REQ-009 Port we  output  1: write enable to the register-file write port.
REQ-010 Port Addr  output  3: register-file write address.
REQ-011 Port wData  output  DATA_W: register-file write data.
REQ-012 Port busy  output  1: high when the FSM is in WRITE.

Function
REQ-013 The FSM SHALL have two states: IDLE and WRITE.
REQ-014 In IDLE with req==0, the FSM SHALL stay in IDLE and outputs SHALL hold their values with we=0 and ack=0.
REQ-015 In IDLE with req!=0, the block SHALL pick one requester round-robin, register its addr/data into Addr/wData and the grantee index, then move to WRITE.
REQ-016 Round-robin search SHALL start at index ptr and proceed ptr, ptr+1, ... modulo 4; the first set req bit SHALL win.
REQ-017 In WRITE, we=1, busy=1 and ack[grantee]=1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-018 On leaving WRITE, ptr SHALL become (grantee+1) mod 4.
REQ-019 Latency from req rising (sampled in IDLE) to we/ack SHALL be 1 cycle; peak throughput SHALL be one write per 2 cycles.
REQ-020 A requester SHALL see at most one ack per request; a req still high in the cycle after its ack SHALL be treated as a new request.
REQ-021 Requests arriving while in WRITE SHALL be ignored until the FSM re-enters IDLE; no request SHALL be lost while it is held.
REQ-022 ack, we and busy SHALL all be 0 in IDLE.

Reset
REQ-023 With reset=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, we=0, ack=0, busy=0, Addr=0, wData=0, grantee=0.
REQ-024 Reset asserted during WRITE SHALL abort the write: we and ack SHALL be 0 from the next edge, and no ack SHALL be issued for the aborted request.

Configuration
REQ-025 Macro WRITE_ARB_R0_PROTECT_EN: when defined, a granted write with Addr==0 SHALL still pulse ack but keep we=0, so register 0 stays zero.
REQ-026 When WRITE_ARB_R0_PROTECT_EN is undefined, writes to address 0 SHALL behave like any other address.

Structure
REQ-027 Package write_arb_pkg SHALL hold NUM_REQ=4, ADDR_W=3 and the state enum {IDLE, WRITE}.
REQ-028 The round-robin selection SHALL be a combinational sub-module rr_priority_picker with inputs req[3:0] and ptr[1:0], and outputs valid and idx[1:0].
REQ-029 The block's we/Addr outputs SHALL directly drive the register file's existing we/Addr decode input.

Verification
REQ-030 Reset, then req=0001 with addr0=5 and data0=0xA5: next cycle we=1, Addr=5, wData=0xA5, ack=0001; the cycle after that we=0.
REQ-031 req=1111 held constantly: grants SHALL occur in order 0,1,2,3,0 on alternate cycles, ack pulses spaced 2 cycles apart.
REQ-032 ptr=2 with req=0011: grantee SHALL be 0, then 1; requesters 2 and 3 SHALL never be acked.
REQ-033 Assert reset in the WRITE cycle of grant 3: no ack[3], we=0; after reset, a held req[3] SHALL be granted first (ptr=0, only req 3 set).
REQ-034 With WRITE_ARB_R0_PROTECT_EN, req=0100 with addr2=0: ack=0100 with we=0; without the macro, we=1 and Addr=0.
